// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_tx_state_t       : transmitter frame states
//   UART_DEFAULT_BAUD_DIV : clocks per bit for 115200 baud from 100 MHz
//   UART_IDLE_LEVEL       : line level between frames
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int unsigned UART_DEFAULT_BAUD_DIV = 868;
  localparam logic        UART_IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART transmitter and receiver.
//   BAUD_DIV : clock cycles per bit period (>= 2)
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset
//   clear    : holds the counter at zero (used while the line is idle)
//   tick     : high on the final cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_DEFAULT_BAUD_DIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge CLK) begin
    if (RST || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: drains a byte FIFO and serializes each entry as 8N1, or as 8E1 when
// UART_TX_PARITY_EN is defined.
//   WIDTH      : data bits per frame (matches the FIFO width)
//   BAUD_DIV   : clock cycles per bit (>= 2)
//   CLK, RST   : clock and synchronous active-high reset
//   fifo_data  : head-of-FIFO data, valid while fifo_empty is low
//   fifo_empty : FIFO empty flag
//   fifo_rd    : one-cycle pop strobe (combinational)
//   tx         : registered serial line, idle high
//   busy       : high from the pop through the end of the stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned BAUD_DIV = UART_DEFAULT_BAUD_DIV
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned BCW = $clog2(WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  // Plain constants keep the state register a bare vector.
  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]       state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next, shifted;
  logic [BCW-1:0]   bit_cnt, bit_cnt_next;
  logic             tx_next;
  logic             tick;
  logic             line_free;
`ifdef UART_TX_PARITY_EN
  logic             parity, parity_next;
`endif

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_gen (
    .CLK  (CLK),
    .RST  (RST),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  // The line is free while idle and on the last cycle of a stop bit, which is
  // what lets frames run back to back without an idle gap.
  assign line_free = (state == ST_IDLE) || ((state == ST_STOP) && tick);
  assign fifo_rd   = line_free && !fifo_empty && !RST;
  assign busy      = (state != ST_IDLE);
  assign shifted   = shreg >> 1;

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    tx_next      = tx;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif
    case (state)
      ST_IDLE: begin
        tx_next = UART_IDLE_LEVEL;
        if (fifo_rd) begin
          state_next   = ST_START;
          shreg_next   = fifo_data;
          bit_cnt_next = '0;
          tx_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^fifo_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
          tx_next      = shreg[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = ST_PARITY;
            tx_next    = parity;
`else
            state_next = ST_STOP;
            tx_next    = UART_IDLE_LEVEL;
`endif
          end else begin
            shreg_next   = shifted;
            bit_cnt_next = bit_cnt + 1'b1;
            tx_next      = shifted[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
          tx_next    = UART_IDLE_LEVEL;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (fifo_rd) begin
            state_next   = ST_START;
            shreg_next   = fifo_data;
            bit_cnt_next = '0;
            tx_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next  = ^fifo_data;
`endif
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_next;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that drains a byte FIFO and serializes each byte onto a single line as 8N1 (optionally 8E1). It is the consumer end of the transmit FIFO: it pops one entry whenever the FIFO is non-empty and the line is free, and it drives the board TX pin. The UART receiver sits on the opposite side and fills the receive FIFO.

## Interface
- `WIDTH`, default 8: data bits per frame; must match the FIFO data width.
- `BAUD_DIV`, default 868: clock cycles per bit (100 MHz / 115200); legal range ≥ 2.
- `CLK` input, 1 bit: the single clock; all logic updates on its rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `fifo_data` input, `WIDTH` bits: head-of-FIFO data; valid whenever `fifo_empty` = 0.
- `fifo_empty` input, 1 bit: FIFO empty flag.
- `fifo_rd` output, 1 bit: pop strobe, one cycle wide; the FIFO read flag.
- `tx` output, 1 bit: serial line; idle high.
- `busy` output, 1 bit: high from the pop through the end of the stop bit.

## Operation
- Reset values: `tx` = 1, `fifo_rd` = 0, `busy` = 0; state = IDLE; bit and baud counters = 0.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - If `fifo_empty` = 0, `fifo_rd` = 1 combinationally in that cycle.
  - On that edge, `fifo_data` is captured into the shift register and the state moves to START.
  - If the FIFO is empty, the block stays in IDLE with `tx` = 1.
- START: `tx` = 0 for `BAUD_DIV` cycles, then DATA.
- DATA:
  - `WIDTH` bits are sent LSB first, each for `BAUD_DIV` cycles.
  - The shift register shifts right when a bit period ends.
  - After bit `WIDTH`-1 the state moves to PARITY, or to STOP when parity is not compiled in.
- PARITY: `tx` = XOR of the captured byte (even parity), held for `BAUD_DIV` cycles.
- STOP: `tx` = 1 for `BAUD_DIV` cycles. At the final cycle of the stop bit:
  - If `fifo_empty` = 0: pop and capture on that edge, then go straight to START. There is no idle gap.
  - Otherwise go to IDLE.
- `fifo_rd` is asserted only in IDLE, or in the last STOP cycle, and only when `fifo_empty` = 0. The block never pops an empty FIFO, and pops exactly once per frame.
- Baud counter:
  - Width `$clog2(BAUD_DIV)`.
  - Counts 0..`BAUD_DIV`-1; wraps to 0 on the bit-period end.
  - Cleared on every state entry from IDLE.
- Bit counter: width `$clog2(WIDTH)+1`.
- `busy` = (state ≠ IDLE).
- Reset mid-frame: on the next edge `tx` = 1 and the state is IDLE. The byte in flight is lost. No pop occurs in the reset cycle.

## Timing
- `tx` is a registered output with no combinational path from inputs.
- `fifo_rd` is a Mealy output (from `fifo_empty` and state) with no registered delay.
- Start latency: `fifo_empty` falls and is sampled at edge N while in IDLE. `fifo_rd` is high during the cycle before edge N, and `tx` falls after edge N.
- Frame length: (`WIDTH`+2)·`BAUD_DIV` cycles (8N1: 10·`BAUD_DIV`), or (`WIDTH`+3)·`BAUD_DIV` with parity.
- Back-to-back frames: the next start bit begins on the edge immediately following the last stop cycle.
- Throughput: one byte per frame length.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state and the parity XOR are compiled in.
  - Frame is 8E1, (`WIDTH`+3)·`BAUD_DIV` cycles.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP; frame is 8N1.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `UART_DEFAULT_BAUD_DIV` = 868;
  - `UART_IDLE_LEVEL` = 1'b1.
- The UART receiver uses the same package.
- One sub-module, `uart_baud_gen`:
  - inputs: parameter `BAUD_DIV`, `CLK`, `RST`, `clear`;
  - output: `tick`, high on the final cycle of each bit period.
  - The receiver reuses it.

## Test plan
- Reset: assert `RST` for 3 cycles with `fifo_empty` = 0. Require `tx` = 1, `fifo_rd` = 0, `busy` = 0 throughout, and no pop.
- Single byte, `BAUD_DIV` = 4, byte 0x55, 8N1:
  - exactly one `fifo_rd` pulse;
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1;
  - `busy` high for 40 cycles.
- Back-to-back, FIFO holds 0xA3 then 0xFF:
  - two pops;
  - second start bit begins exactly 40 cycles after the first;
  - no idle-high gap between the frames.
- Empty FIFO: `fifo_empty` = 1 for 100 cycles. Require `fifo_rd` = 0 and `tx` = 1 throughout.
- Reset mid-frame: assert `RST` during data bit 3. Require `tx` = 1 and `busy` = 0 on the next edge. After release, the next queued byte is sent as a complete frame.
- With `UART_TX_PARITY_EN`, byte 0x07: parity bit = 1 and frame length = 44 cycles. Repeat with byte 0x03: parity bit = 0.
